// File: rtl/tmds_gearbox.sv
// tmds_gearbox: per-lane parallel-to-serial gearbox with shared word boundary, bitslip and idle fill on underflow
module tmds_gearbox #(
    parameter int CHANNELS = 4,
    parameter int WORD_W = 10,
    parameter int DDR = 1,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100,
    localparam int BPC = DDR != 0 ? 2 : 1
) (
    input  logic                       clk_shift,
    input  logic                       reset_n,
    input  logic [CHANNELS*WORD_W-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       bitslip,
    output logic [CHANNELS*BPC-1:0]    out_bits,
    output logic                       underflow,
    output logic [15:0]                underflow_cnt
);
    localparam int PH = WORD_W / BPC;
    localparam int PW = PH > 1 ? $clog2(PH) : 1;

    if (WORD_W % BPC != 0) begin : g_bad_width
        $error("WORD_W must be a multiple of the bits emitted per clock");
    end

    logic [PW-1:0]     phase_q, phase_d;
    logic [WORD_W-1:0] sr_q [CHANNELS];
    logic [WORD_W-1:0] sr_d [CHANNELS];
    logic              underflow_q, underflow_d;
    logic [15:0]       underflow_cnt_q, underflow_cnt_d;
    logic              load;

    // bitslip freezes the phase while the lanes keep shifting, stretching the current word by one slot
    always_comb begin
        load = reset_n && phase_q == PW'(PH - 1) && !bitslip;
        phase_d = bitslip ? phase_q : (phase_q == PW'(PH - 1) ? '0 : phase_q + PW'(1));
        underflow_d = underflow_q | (load & ~in_valid);
        underflow_cnt_d = (load && !in_valid && underflow_cnt_q != 16'hFFFF) ? underflow_cnt_q + 16'd1 : underflow_cnt_q;
        for (int i = 0; i < CHANNELS; i++)
            sr_d[i] = load ? (in_valid ? in_data[i*WORD_W +: WORD_W] : IDLE_WORD) : sr_q[i] >> BPC;
    end

    always_ff @(posedge clk_shift) begin
        if (!reset_n) begin
            phase_q <= '0;
            for (int i = 0; i < CHANNELS; i++)
                sr_q[i] <= IDLE_WORD;
            underflow_q <= 1'b0;
            underflow_cnt_q <= 16'd0;
        end else begin
            phase_q <= phase_d;
            sr_q <= sr_d;
            underflow_q <= underflow_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign out_bits[c*BPC +: BPC] = sr_q[c][BPC-1:0];
    end

    assign in_ready = load;
    assign underflow = underflow_q;
    assign underflow_cnt = underflow_cnt_q;
endmodule
